// File: rtl/dmux_stream_router.sv
// Valid/ready stream router built around a fixed-latency pipelined demux.
// Credits per output reserve FIFO space at accept time because the demux pipeline cannot stall.

module dmux_lfmr #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned OUTPUT_COUNT = 4,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned TYPE         = 0,
  localparam int unsigned SEL_W       = $clog2(OUTPUT_COUNT) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              data,
  input  logic [SEL_W-1:0]              sel,
  output logic [WIDTH*OUTPUT_COUNT-1:0] lanes
);

  if (TYPE != 0) begin : g_bad_type
    $error("dmux_lfmr: only TYPE 0 (fixed latency) is supported");
  end

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;

  if (LATENCY == 0) begin : g_comb
    assign data_q = data;
    assign sel_q  = sel;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_p [LATENCY];
    logic [SEL_W-1:0] sel_p  [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < LATENCY; k++) begin
          data_p[k] <= '0;
          sel_p[k]  <= '1;
        end
      end else begin
        data_p[0] <= data;
        sel_p[0]  <= sel;
        for (int unsigned k = 1; k < LATENCY; k++) begin
          data_p[k] <= data_p[k-1];
          sel_p[k]  <= sel_p[k-1];
        end
      end
    end

    assign data_q = data_p[LATENCY-1];
    assign sel_q  = sel_p[LATENCY-1];
  end

  always_comb begin
    lanes = '0;
    for (int unsigned k = 0; k < OUTPUT_COUNT; k++) begin
      if (sel_q == SEL_W'(k)) lanes[k*WIDTH +: WIDTH] = data_q;
    end
  end

endmodule

module dmux_stream_router #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned OUTPUT_COUNT = 4,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TYPE         = 0,
  localparam int unsigned SEL_W       = $clog2(OUTPUT_COUNT) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WIDTH-1:0]              s_data,
  input  logic [SEL_W-1:0]              s_dest,
  output logic [OUTPUT_COUNT-1:0]       m_valid,
  input  logic [OUTPUT_COUNT-1:0]       m_ready,
  output logic [WIDTH*OUTPUT_COUNT-1:0] m_data,
  output logic [7:0]                    drop_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [SEL_W-1:0] DEST_LIMIT = SEL_W'(OUTPUT_COUNT);
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(FIFO_DEPTH);

  logic                          live;
  logic                          legal;
  logic                          has_credit;
  logic                          accept;
  logic                          issue;
  logic [SEL_W-1:0]              dmx_sel;
  logic [WIDTH*OUTPUT_COUNT-1:0] lanes;
  logic                          tag_valid;
  logic [SEL_W-1:0]              tag_dest;
  logic [OUTPUT_COUNT-1:0]       avail;
  logic [OUTPUT_COUNT-1:0]       push;
  logic [OUTPUT_COUNT-1:0]       pop;

  // Holds s_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_comb begin
    legal      = s_dest < DEST_LIMIT;
    has_credit = 1'b0;
    for (int unsigned k = 0; k < OUTPUT_COUNT; k++) begin
      if (s_dest == SEL_W'(k)) has_credit = avail[k];
    end
    s_ready = live && (legal ? has_credit : 1'b1);
    accept  = s_valid && s_ready;
    issue   = accept && legal;
    dmx_sel = issue ? s_dest : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          drop_count <= '0;
    else if (accept && !legal && drop_count != 8'hFF)    drop_count <= drop_count + 8'd1;
  end

  dmux_lfmr #(
    .WIDTH(WIDTH),
    .OUTPUT_COUNT(OUTPUT_COUNT),
    .LATENCY(LATENCY),
    .TYPE(TYPE)
  ) u_dmux (
    .clk(clk),
    .rst_n(rst_n),
    .data(s_data),
    .sel(dmx_sel),
    .lanes(lanes)
  );

  // Tag pipeline mirrors the demux latency so capture knows which lane is live.
  if (LATENCY == 0) begin : g_tag_comb
    assign tag_valid = issue;
    assign tag_dest  = s_dest;
  end else begin : g_tag_pipe
    logic [LATENCY-1:0] vld_p;
    logic [SEL_W-1:0]   dest_p [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= '0;
        for (int unsigned k = 0; k < LATENCY; k++) dest_p[k] <= '0;
      end else begin
        vld_p[0]  <= issue;
        dest_p[0] <= s_dest;
        for (int unsigned k = 1; k < LATENCY; k++) begin
          vld_p[k]  <= vld_p[k-1];
          dest_p[k] <= dest_p[k-1];
        end
      end
    end

    assign tag_valid = vld_p[LATENCY-1];
    assign tag_dest  = dest_p[LATENCY-1];
  end

  for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_lane
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] credit;
    logic             dec;

    assign dec        = accept && (s_dest == SEL_W'(i));
    assign push[i]    = tag_valid && (tag_dest == SEL_W'(i));
    assign pop[i]     = m_valid[i] && m_ready[i];
    assign avail[i]   = credit != '0;
    assign m_valid[i] = count != '0;
    assign m_data[i*WIDTH +: WIDTH] = m_valid[i] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= lanes[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        credit <= FULL;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        if (push[i] && !pop[i])      count <= count + 1'b1;
        else if (pop[i] && !push[i]) count <= count - 1'b1;
        if (dec && !pop[i])          credit <= credit - 1'b1;
        else if (pop[i] && !dec)     credit <= credit + 1'b1;
      end
    end

    a_credit_bounds: assert property (@(posedge clk) disable iff (!rst_n)
      (credit <= FULL) && !(dec && !pop[i] && credit == '0) && !(pop[i] && !dec && credit == FULL));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push[i] && !pop[i] && count == FULL));
  end

endmodule

// File: doc/dmux_stream_router.md
Name: dmux_stream_router

Overview:
- Stream-side wrapper around the fixed-latency pipelined demultiplexer (dmux_lfmr) that makes it usable with valid/ready flow control.
- Accepts a single input stream tagged with a destination index and issues it into the demux.
- Tracks validity alongside the demux latency and captures each lane into a per-output FIFO.
- Uses credit-based backpressure, because the demux pipeline itself cannot stall.

Parameters:
- WIDTH, 8, data width per beat.
- OUTPUT_COUNT, 4, number of output streams; >=2.
- LATENCY, 2, latency passed to the internal demux; the valid/dest tag pipeline is exactly this many stages; 0 means combinational.
- FIFO_DEPTH, 4, entries per output FIFO; power of two, >=2.
- TYPE, 0, forwarded to the demux; only 0 (fixed latency) is supported, any other value is rejected at elaboration.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  WIDTH  input beat payload.
- s_dest  in  $clog2(OUTPUT_COUNT)+1  destination index; MSB-extended to match the demux sel width.
- m_valid  out  OUTPUT_COUNT  per-output valid, bit i = output i.
- m_ready  in  OUTPUT_COUNT  per-output ready.
- m_data  out  WIDTH*OUTPUT_COUNT  output i payload at [i*WIDTH+:WIDTH].
- drop_count  out  8  saturating count of beats dropped for an illegal destination.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all FIFOs empty, credits[i]=FIFO_DEPTH, tag pipeline cleared, drop_count=0.
  - m_valid=0 and m_data=0 while in reset.
  - s_ready=0 while rst_n low and for the first cycle after release.
  - Reset mid-operation discards in-flight beats and FIFO contents with no error indication.
- Credits:
  - One counter per output, width $clog2(FIFO_DEPTH+1).
  - credit[i] = FIFO_DEPTH - (FIFO occupancy + beats in flight to i).
  - Decrement on accept with s_dest==i; increment on m_valid[i]&m_ready[i].
  - Both in the same cycle leaves the counter unchanged.
  - Must never underflow or exceed FIFO_DEPTH; an assertion is required.
- s_ready:
  - Combinational: (s_dest<OUTPUT_COUNT) ? credit[s_dest]!=0 : 1.
  - May depend on s_dest; the upstream must hold s_data/s_dest stable while s_valid is high and not accepted.
- Illegal destination (s_dest>=OUTPUT_COUNT):
  - Beat is accepted and dropped; no demux write.
  - drop_count increments and saturates at 255.
- Issue:
  - On accept, s_data and s_dest drive demux in/sel.
  - The tag pipeline captures {1'b1, s_dest}. Non-accept cycles push {0, x} and drive sel with all ones, so no lane is written.
- Capture:
  - When the tag pipeline output is valid with dest d (exactly LATENCY cycles after accept), lane d of the demux output is written into FIFO d.
  - Other lanes are ignored; demux output is zero on non-selected lanes.
  - The credit scheme guarantees FIFO d is not full, so capture never drops.
- Output FIFOs:
  - Independent first-word-fall-through FIFOs with registered storage, pointers wrap modulo FIFO_DEPTH.
  - m_valid[i] = FIFO i non-empty; m_data lane i = FIFO head, held stable while m_valid[i] & !m_ready[i].
  - Push and pop on the same cycle are both allowed, including when full (pop frees) and when empty: no bypass, the pushed data appears the next cycle.
- Latency: accept to m_valid rise is LATENCY+1 cycles when the target FIFO is empty.
- Throughput: one beat per cycle, sustained, while the target has credit; lanes do not block each other (no head-of-line blocking across destinations).
- Ordering: per-destination order is preserved; no ordering guarantee across destinations.

Test Plan:
- Reset, then 4 beats 0x10..0x13 to dest 0,1,2,3 on consecutive cycles with all m_ready=1 -> each m_valid[i] high exactly 3 cycles after its accept, carrying 0x10+i; drop_count=0.
- m_ready[2]=0, send 6 beats to dest 2 -> s_ready falls after the 4th accept. Then raise m_ready[2] -> beats pop in order; s_ready returns the cycle after the first pop; all 6 delivered in order.
- Dest 2 is full (m_ready[2]=0) while beats alternate dest 2 and dest 1 -> dest 1 beats keep flowing, stalling only on beats whose s_dest=2.
- s_dest=5 with s_valid held 300 cycles -> s_ready=1 throughout, no m_valid ever, drop_count saturates at 255.
- FIFO 0 full (credit 0) while m_ready[0] pops and a new beat to dest 0 is offered in the same cycle -> accepted the next cycle; credit never leaves 0..4; FIFO content correct.
- Assert rst_n low mid-burst with 2 beats in flight -> all m_valid=0 immediately (asynchronously); after release no stale beat appears and credits read 4.
